// File: rtl/i2s_tx_framer_pkg.sv
// Shared audio definitions for the DAC-side I2S framer.
package i2s_tx_framer_pkg;

  localparam int unsigned DEFAULT_WORD_SIZE = 32;
  // Storage width of one channel inside the stereo pair; WORD_SIZE must not exceed it.
  localparam int unsigned SAMPLE_W          = 32;

  localparam int unsigned UNDERRUN_REPEAT = 0;
  localparam int unsigned UNDERRUN_ZERO   = 1;

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_lrck_sync.sv
// Phase-lock of the DAC LR clock to the ADC LR clock: edge detect, compare, lock/slip tracking.
module i2s_lrck_sync #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned CNT_W     = $clog2(WORD_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_en,
  input  logic             ref_lrck,
  input  logic             lrck,
  input  logic [CNT_W-1:0] word_cnt,
  output logic             realign_c,
  output logic             locked,
  output logic [7:0]       slip_cnt
);

  logic ref_d;
  logic ref_rise_c;
  logic at_toggle_c;

  // A reference rise is already aligned when the free-running counter is about to enter the right half.
  always_comb begin
    ref_rise_c  = ref_lrck & ~ref_d;
    at_toggle_c = ~lrck && (word_cnt == CNT_W'(WORD_SIZE - 1));
    realign_c   = sync_en & ref_rise_c & ~at_toggle_c;
  end

  // Reference delay, lock status and saturating slip counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_d    <= 1'b0;
      locked   <= 1'b0;
      slip_cnt <= 8'd0;
    end else begin
      ref_d <= ref_lrck;
      if (!sync_en) begin
        locked <= 1'b0;
      end else if (ref_rise_c) begin
        locked <= at_toggle_c;
      end
      if (realign_c && (slip_cnt != 8'hFF)) begin
        slip_cnt <= slip_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/i2s_tx_framer.sv
// DAC-side I2S frame timing with a double-buffered stereo word pair.
module i2s_tx_framer
  import i2s_tx_framer_pkg::*;
#(
  parameter int unsigned WORD_SIZE     = DEFAULT_WORD_SIZE,
  parameter int unsigned CNT_W         = $clog2(WORD_SIZE),
  parameter int unsigned UNDERRUN_MODE = UNDERRUN_REPEAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] s_l_data,
  input  logic [WORD_SIZE-1:0] s_r_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 sync_en,
  input  logic                 ref_lrck,
  output logic                 lrck,
  output logic [WORD_SIZE-1:0] tx_word_l,
  output logic [WORD_SIZE-1:0] tx_word_r,
  output logic                 frame_start,
  output logic                 underrun,
  input  logic                 underrun_clr,
  output logic                 locked,
  output logic [7:0]           slip_cnt
);

  logic [CNT_W-1:0] word_cnt;
  logic             wrap_c;
  logic             realign_c;
  logic             load_now_c;
  logic             accept_c;
  stereo_sample_t   hold;
  logic             hold_valid;
  stereo_sample_t   tx_pair;

  i2s_lrck_sync #(
    .WORD_SIZE (WORD_SIZE),
    .CNT_W     (CNT_W)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sync_en   (sync_en),
    .ref_lrck  (ref_lrck),
    .lrck      (lrck),
    .word_cnt  (word_cnt),
    .realign_c (realign_c),
    .locked    (locked),
    .slip_cnt  (slip_cnt)
  );

  // Frame load at the end of the right half unless a realign truncates the frame.
  always_comb begin
    wrap_c     = (word_cnt == CNT_W'(WORD_SIZE - 1));
    load_now_c = wrap_c && lrck && !realign_c;
    s_ready    = ~hold_valid | load_now_c;
    accept_c   = s_valid && s_ready;
  end

  // Word counter and LR clock; a realign restarts the right half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      lrck     <= 1'b0;
    end else if (realign_c) begin
      word_cnt <= '0;
      lrck     <= 1'b1;
    end else if (wrap_c) begin
      word_cnt <= '0;
      lrck     <= ~lrck;
    end else begin
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

  // Holding register, transmit pair and status; an accept on a load cycle refills hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold        <= '0;
      hold_valid  <= 1'b0;
      tx_pair     <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= load_now_c;
      if (load_now_c) begin
        if (hold_valid) begin
          tx_pair    <= hold;
          hold_valid <= 1'b0;
        end else if (UNDERRUN_MODE == UNDERRUN_ZERO) begin
          tx_pair <= '0;
        end
      end
      if (accept_c) begin
        hold.l     <= SAMPLE_W'(s_l_data);
        hold.r     <= SAMPLE_W'(s_r_data);
        hold_valid <= 1'b1;
      end
      if (load_now_c && !hold_valid) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

  assign tx_word_l = WORD_SIZE'(tx_pair.l);
  assign tx_word_r = WORD_SIZE'(tx_pair.r);

endmodule

// File: tb/tb_i2s_tx_framer.sv
// Directed bench for i2s_tx_framer: repeat-mode and zero-mode instances share stimulus.
module tb_i2s_tx_framer;

  localparam int unsigned WS = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [WS-1:0] s_l_data = '0;
  logic [WS-1:0] s_r_data = '0;
  logic          s_valid = 1'b0;
  logic          sync_en = 1'b0;
  logic          ref_lrck = 1'b0;
  logic          underrun_clr = 1'b0;

  logic          s_ready, lrck, frame_start, underrun, locked;
  logic [WS-1:0] tx_word_l, tx_word_r;
  logic [7:0]    slip_cnt;

  logic          z_s_ready, z_lrck, z_frame_start, z_underrun, z_locked;
  logic [WS-1:0] z_tx_word_l, z_tx_word_r;
  logic [7:0]    z_slip_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_tx_framer #(.WORD_SIZE(WS), .UNDERRUN_MODE(0)) dut (
    .clk(clk), .rst(rst), .s_l_data(s_l_data), .s_r_data(s_r_data),
    .s_valid(s_valid), .s_ready(s_ready), .sync_en(sync_en), .ref_lrck(ref_lrck),
    .lrck(lrck), .tx_word_l(tx_word_l), .tx_word_r(tx_word_r),
    .frame_start(frame_start), .underrun(underrun), .underrun_clr(underrun_clr),
    .locked(locked), .slip_cnt(slip_cnt)
  );

  i2s_tx_framer #(.WORD_SIZE(WS), .UNDERRUN_MODE(1)) dut_zero (
    .clk(clk), .rst(rst), .s_l_data(s_l_data), .s_r_data(s_r_data),
    .s_valid(s_valid), .s_ready(z_s_ready), .sync_en(sync_en), .ref_lrck(ref_lrck),
    .lrck(z_lrck), .tx_word_l(z_tx_word_l), .tx_word_r(z_tx_word_r),
    .frame_start(z_frame_start), .underrun(z_underrun), .underrun_clr(underrun_clr),
    .locked(z_locked), .slip_cnt(z_slip_cnt)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset values while rst is held, then release on a falling edge (edge count e=0).
  task automatic test_reset();
    tick(2);
    checks++; if (lrck !== 1'b0) begin errors++; $display("FAIL reset_lrck: got %b want 0", lrck); end
    checks++; if (tx_word_l !== '0 || tx_word_r !== '0) begin errors++; $display("FAIL reset_tx: got %h/%h want 0/0", tx_word_l, tx_word_r); end
    checks++; if (frame_start !== 1'b0 || underrun !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL reset_flags: fs=%b ur=%b lk=%b want 0", frame_start, underrun, locked); end
    checks++; if (slip_cnt !== 8'd0) begin errors++; $display("FAIL reset_slip: got %0d want 0", slip_cnt); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", s_ready); end
    rst = 1'b0;
  endtask

  // Free run with no data: lrck half-period 32, first load at e=64 underruns.
  task automatic test_free_run();
    tick(31); // e=31
    checks++; if (lrck !== 1'b0) begin errors++; $display("FAIL fr_lrck31: got %b want 0", lrck); end
    tick(1);  // e=32
    checks++; if (lrck !== 1'b1) begin errors++; $display("FAIL fr_lrck32: got %b want 1", lrck); end
    tick(31); // e=63
    checks++; if (frame_start !== 1'b0 || lrck !== 1'b1) begin errors++; $display("FAIL fr_pre_load: fs=%b lrck=%b want 0/1", frame_start, lrck); end
    tick(1);  // e=64
    checks++; if (frame_start !== 1'b1 || lrck !== 1'b0) begin errors++; $display("FAIL fr_load: fs=%b lrck=%b want 1/0", frame_start, lrck); end
    checks++; if (underrun !== 1'b1 || z_underrun !== 1'b1) begin errors++; $display("FAIL fr_underrun: got %b/%b want 1/1", underrun, z_underrun); end
    checks++; if (tx_word_l !== '0 || z_tx_word_l !== '0) begin errors++; $display("FAIL fr_tx: got %h/%h want 0/0", tx_word_l, z_tx_word_l); end
    tick(1);  // e=65
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL fr_pulse: got %b want 0", frame_start); end
  endtask

  // Handshake, back-to-back accept on the load cycle, then starvation in both modes.
  task automatic test_handshake_underrun();
    s_valid  = 1'b1;
    s_l_data = 32'h1234_5678;
    s_r_data = 32'hFEDC_BA98;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_empty: got %b want 1", s_ready); end
    tick(1);  // e=66
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL hs_ready_full: got %b want 0", s_ready); end
    s_l_data = 32'h0000_0005;
    s_r_data = 32'hFFFF_FFFB;
    tick(61); // e=127, load cycle
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL hs_ready_load: got %b want 1", s_ready); end
    checks++; if (tx_word_l !== '0) begin errors++; $display("FAIL hs_tx_preload: got %h want 0", tx_word_l); end
    tick(1);  // e=128
    checks++; if (tx_word_l !== 32'h1234_5678 || tx_word_r !== 32'hFEDC_BA98) begin errors++; $display("FAIL hs_tx_pair1: got %h/%h want 12345678/fedcba98", tx_word_l, tx_word_r); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL hs_frame_start: got %b want 1", frame_start); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL hs_b2b_hold: got %b want 0", s_ready); end
    s_valid = 1'b0;
    underrun_clr = 1'b1;
    tick(1);  // e=129
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear1: got %b want 0", underrun); end
    tick(63); // e=192
    checks++; if (tx_word_l !== 32'h0000_0005 || tx_word_r !== 32'hFFFF_FFFB) begin errors++; $display("FAIL hs_tx_pair2: got %h/%h want 00000005/fffffffb", tx_word_l, tx_word_r); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_none: got %b want 0", underrun); end
    tick(64); // e=256, starved load
    checks++; if (tx_word_l !== 32'h0000_0005 || tx_word_r !== 32'hFFFF_FFFB) begin errors++; $display("FAIL ur_repeat: got %h/%h want 00000005/fffffffb", tx_word_l, tx_word_r); end
    checks++; if (z_tx_word_l !== '0 || z_tx_word_r !== '0) begin errors++; $display("FAIL ur_zero: got %h/%h want 0/0", z_tx_word_l, z_tx_word_r); end
    checks++; if (underrun !== 1'b1 || z_underrun !== 1'b1) begin errors++; $display("FAIL ur_set: got %b/%b want 1/1", underrun, z_underrun); end
    underrun_clr = 1'b1;
    tick(1);  // e=257
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear2: got %b want 0", underrun); end
    tick(62); // e=319, clear coincides with a starved load
    underrun_clr = 1'b1;
    tick(1);  // e=320
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_set_wins: got %b want 1", underrun); end
  endtask

  // Forced realign at word_cnt=10 of the left half, then a lock on the next aligned rise.
  task automatic test_sync();
    sync_en = 1'b1;
    tick(10); // e=330
    ref_lrck = 1'b1;
    tick(1);  // e=331
    checks++; if (lrck !== 1'b1 || slip_cnt !== 8'd1 || locked !== 1'b0) begin errors++; $display("FAIL sync_realign: lrck=%b slip=%0d lk=%b want 1/1/0", lrck, slip_cnt, locked); end
    tick(1);  // e=332
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL sync_no_load: got %b want 0", frame_start); end
    tick(30); // e=362, counter restarted at 0 so still in the right half
    checks++; if (lrck !== 1'b1) begin errors++; $display("FAIL sync_cnt_restart: got %b want 1", lrck); end
    ref_lrck = 1'b0;
    tick(1);  // e=363
    checks++; if (lrck !== 1'b0 || frame_start !== 1'b1) begin errors++; $display("FAIL sync_frame: lrck=%b fs=%b want 0/1", lrck, frame_start); end
    tick(31); // e=394
    ref_lrck = 1'b1;
    tick(1);  // e=395
    checks++; if (lrck !== 1'b1 || locked !== 1'b1 || slip_cnt !== 8'd1) begin errors++; $display("FAIL sync_lock: lrck=%b lk=%b slip=%0d want 1/1/1", lrck, locked, slip_cnt); end
    sync_en = 1'b0;
    tick(1);  // e=396
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sync_disable: got %b want 0", locked); end
  endtask

  // Misaligned reference rises every two cycles drive slip_cnt into saturation.
  task automatic test_slip_saturate();
    sync_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ref_lrck = 1'b0; tick(1);
      ref_lrck = 1'b1; tick(1);
    end
    checks++; if (slip_cnt !== 8'd101) begin errors++; $display("FAIL slip_101: got %0d want 101", slip_cnt); end
    for (int i = 0; i < 200; i++) begin
      ref_lrck = 1'b0; tick(1);
      ref_lrck = 1'b1; tick(1);
    end
    checks++; if (slip_cnt !== 8'd255 || z_slip_cnt !== 8'd255) begin errors++; $display("FAIL slip_sat: got %0d/%0d want 255/255", slip_cnt, z_slip_cnt); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL slip_locked: got %b want 0", locked); end
    sync_en  = 1'b0;
    ref_lrck = 1'b0;
  endtask

  // Asynchronous reset mid-frame with a full holding register.
  task automatic test_reset_mid();
    s_valid  = 1'b1;
    s_l_data = 32'h1111_1111;
    s_r_data = 32'h2222_2222;
    tick(1);
    s_valid = 1'b0;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rm_hold_full: got %b want 0", s_ready); end
    #2 rst = 1'b1;
    #1;
    checks++; if (lrck !== 1'b0 || frame_start !== 1'b0 || underrun !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL rm_async_flags: lrck=%b fs=%b ur=%b lk=%b want 0", lrck, frame_start, underrun, locked); end
    checks++; if (tx_word_l !== '0 || tx_word_r !== '0 || slip_cnt !== 8'd0) begin errors++; $display("FAIL rm_async_data: tx=%h/%h slip=%0d want 0", tx_word_l, tx_word_r, slip_cnt); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rm_async_ready: got %b want 1", s_ready); end
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    checks++; if (s_ready !== 1'b1 || lrck !== 1'b0) begin errors++; $display("FAIL rm_release: ready=%b lrck=%b want 1/0", s_ready, lrck); end
    s_valid = 1'b1;
    tick(1);
    s_valid = 1'b0;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rm_accept: got %b want 0", s_ready); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_handshake_underrun();
    test_sync();
    test_slip_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
